// File: rtl/pcie_tl_tx_arbiter.sv
// Credit-gated P/NP/CPL round-robin arbiter onto the 256-bit TL transmit path.
// Define PCIE_TX_ARB_CPL_PRIO_EN to give eligible completions strict priority.
module pcie_tl_tx_arbiter #(
  parameter int DATA_WIDTH = 256,
  parameter int LEN_WIDTH  = 11,
  parameter int HDR_CRD_W  = 8,
  parameter int DATA_CRD_W = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fc_init_valid,
  input  logic [3*HDR_CRD_W-1:0]  fc_init_hdr,
  input  logic [3*DATA_CRD_W-1:0] fc_init_data,
  input  logic                    fc_upd_valid,
  input  logic [1:0]              fc_upd_class,
  input  logic [HDR_CRD_W-1:0]    fc_upd_hdr,
  input  logic [DATA_CRD_W-1:0]   fc_upd_data,
  input  logic [2:0]              src_valid,
  input  logic [3*DATA_WIDTH-1:0] src_data,
  input  logic [2:0]              src_last,
  input  logic [3*LEN_WIDTH-1:0]  src_len_dw,
  output logic [2:0]              src_ready,
  output logic                    tx_valid,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_last,
  input  logic                    tx_ready,
  output logic [1:0]              tx_class,
  output logic                    fc_err
);

  typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;
  typedef logic [LEN_WIDTH:0]  len_t;
  typedef logic [HDR_CRD_W:0]  hcnt_t;
  typedef logic [DATA_CRD_W:0] dcnt_t;

  state_t                state;
  logic [1:0]            gnt;
  logic [1:0]            ptr;
  logic [HDR_CRD_W-1:0]  hdr_av [3];
  logic [DATA_CRD_W-1:0] data_av [3];
  logic [2:0]            inf_hdr;
  logic [2:0]            inf_data;
  len_t                  len_up [3];
  logic [DATA_CRD_W-1:0] need [3];
  logic [2:0]            elig;
  logic                  pick_vld;
  logic [1:0]            pick;
  logic [1:0]            ptr_nxt;
  logic [1:0]            c0;
  logic [1:0]            c1;
  logic                  grant;
  hcnt_t                 hdr_nxt [3];
  dcnt_t                 data_nxt [3];
  logic [2:0]            sat;

  function automatic logic [1:0] nxt(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      len_up[c] = ({1'b0, src_len_dw[c*LEN_WIDTH +: LEN_WIDTH]} + len_t'(3)) >> 2;
      need[c]   = DATA_CRD_W'(len_up[c]);
      elig[c]   = src_valid[c]
                  && (inf_hdr[c] || hdr_av[c] != '0)
                  && (inf_data[c] || data_av[c] >= need[c]);
    end
  end

  always_comb begin
    pick_vld = |elig;
`ifdef PCIE_TX_ARB_CPL_PRIO_EN
    c0 = (ptr == 2'd1) ? 2'd1 : 2'd0;
    c1 = c0 ^ 2'd1;
    if (elig[2])       pick = 2'd2;
    else if (elig[c0]) pick = c0;
    else               pick = c1;
    // completions never move the P/NP pointer
    ptr_nxt = elig[2] ? ptr : {1'b0, ~pick[0]};
`else
    c0 = ptr;
    c1 = nxt(ptr);
    if (elig[c0])      pick = c0;
    else if (elig[c1]) pick = c1;
    else               pick = nxt(c1);
    ptr_nxt = nxt(pick);
`endif
  end

  assign grant = (state == ARB) && pick_vld;

  // return and deduction net out in one step; the extra MSB flags overflow
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      hdr_nxt[c]  = {1'b0, hdr_av[c]};
      data_nxt[c] = {1'b0, data_av[c]};
      if (fc_upd_valid && fc_upd_class == 2'(c)) begin
        hdr_nxt[c]  = hdr_nxt[c] + {1'b0, fc_upd_hdr};
        data_nxt[c] = data_nxt[c] + {1'b0, fc_upd_data};
      end
      if (grant && pick == 2'(c)) begin
        hdr_nxt[c]  = hdr_nxt[c] - hcnt_t'(1);
        data_nxt[c] = data_nxt[c] - {1'b0, need[c]};
      end
      sat[c] = (!inf_hdr[c] && hdr_nxt[c][HDR_CRD_W])
               || (!inf_data[c] && data_nxt[c][DATA_CRD_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      ptr      <= '0;
      inf_hdr  <= '0;
      inf_data <= '0;
      fc_err   <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        hdr_av[c]  <= '0;
        data_av[c] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: if (fc_init_valid) state <= ARB;
        ARB: if (grant) begin
          gnt   <= pick;
          ptr   <= ptr_nxt;
          state <= XFER;
        end
        XFER: if (tx_valid && tx_ready && tx_last) state <= ARB;
        default: state <= IDLE;
      endcase
      for (int c = 0; c < 3; c++) begin
        if (fc_init_valid) begin
          hdr_av[c]   <= fc_init_hdr[c*HDR_CRD_W +: HDR_CRD_W];
          data_av[c]  <= fc_init_data[c*DATA_CRD_W +: DATA_CRD_W];
          inf_hdr[c]  <= fc_init_hdr[c*HDR_CRD_W +: HDR_CRD_W] == '0;
          inf_data[c] <= fc_init_data[c*DATA_CRD_W +: DATA_CRD_W] == '0;
        end else begin
          if (!inf_hdr[c])
            hdr_av[c] <= hdr_nxt[c][HDR_CRD_W] ? '1
                         : hdr_nxt[c][HDR_CRD_W-1:0];
          if (!inf_data[c])
            data_av[c] <= data_nxt[c][DATA_CRD_W] ? '1
                          : data_nxt[c][DATA_CRD_W-1:0];
        end
      end
      if (!fc_init_valid && |sat) fc_err <= 1'b1;
    end
  end

  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    tx_last   = 1'b0;
    src_ready = '0;
    if (state == XFER) begin
      tx_valid       = src_valid[gnt];
      tx_data        = src_data[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
      tx_last        = src_last[gnt];
      src_ready[gnt] = tx_ready;
    end
  end

  assign tx_class = gnt;

endmodule

// File: tb/tb_pcie_tl_tx_arbiter.sv
// Bench for pcie_tl_tx_arbiter: queue-driven sources, cycle model, directed scenarios.
// Honors PCIE_TX_ARB_CPL_PRIO_EN when it is defined for the build.
module tb_pcie_tl_tx_arbiter;
  localparam int DW = 256;
  localparam int LW = 11;
  localparam int HW = 8;
  localparam int CW = 12;

  typedef struct {
    int len;
    int beats;
    int id;
  } tlp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            fc_init_valid = 1'b0;
  logic [3*HW-1:0] fc_init_hdr = '0;
  logic [3*CW-1:0] fc_init_data = '0;
  logic            fc_upd_valid = 1'b0;
  logic [1:0]      fc_upd_class = '0;
  logic [HW-1:0]   fc_upd_hdr = '0;
  logic [CW-1:0]   fc_upd_data = '0;
  logic [2:0]      src_valid = '0;
  logic [3*DW-1:0] src_data = '0;
  logic [2:0]      src_last = '0;
  logic [3*LW-1:0] src_len_dw = '0;
  logic [2:0]      src_ready;
  logic            tx_valid;
  logic [DW-1:0]   tx_data;
  logic            tx_last;
  logic            tx_ready = 1'b1;
  logic [1:0]      tx_class;
  logic            fc_err;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;

  tlp_t srcq [3][$];
  int   bidx [3];
  bit   hs [3];
  int   glog [$];
  int   gcyc [$];
  int   beats [3];

  // model state
  int mh [3];
  int md [3];
  bit ih [3];
  bit idf [3];
  int mst = 0;
  int mg = 0;
  int mptr = 0;
  bit merr = 1'b0;

  pcie_tl_tx_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .fc_init_valid(fc_init_valid), .fc_init_hdr(fc_init_hdr),
    .fc_init_data(fc_init_data), .fc_upd_valid(fc_upd_valid),
    .fc_upd_class(fc_upd_class), .fc_upd_hdr(fc_upd_hdr),
    .fc_upd_data(fc_upd_data), .src_valid(src_valid),
    .src_data(src_data), .src_last(src_last),
    .src_len_dw(src_len_dw), .src_ready(src_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
    .tx_ready(tx_ready), .tx_class(tx_class), .fc_err(fc_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [DW-1:0] beat_data(int c, int id, int b);
    logic [31:0] w;
    w = {8'(c + 1), 8'(id), 16'(b)};
    return {8{w}};
  endfunction

  task automatic chk(string n, logic [DW-1:0] act, logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // source drivers: advance on the handshake seen at the previous negedge
  always @(negedge clk)
    for (int c = 0; c < 3; c++) hs[c] = src_valid[c] && src_ready[c];

  always @(posedge clk) begin
    #1;
    for (int c = 0; c < 3; c++) begin
      if (hs[c] && srcq[c].size() > 0) begin
        bidx[c]++;
        if (bidx[c] >= srcq[c][0].beats) begin
          void'(srcq[c].pop_front());
          bidx[c] = 0;
        end
      end
      hs[c] = 1'b0;
      if (srcq[c].size() > 0) begin
        src_valid[c] = 1'b1;
        src_data[c*DW +: DW] = beat_data(c, srcq[c][0].id, bidx[c]);
        src_last[c] = (bidx[c] == srcq[c][0].beats - 1);
        src_len_dw[c*LW +: LW] = LW'(srcq[c][0].len);
      end else begin
        src_valid[c] = 1'b0;
        src_data[c*DW +: DW] = '0;
        src_last[c] = 1'b0;
        src_len_dw[c*LW +: LW] = '0;
      end
    end
  end

  always @(negedge clk)
    if (tx_valid && tx_ready) begin
      beats[tx_class]++;
      if (tx_last) begin
        glog.push_back(int'(tx_class));
        gcyc.push_back(cyc);
      end
    end

  // model and per-cycle compare
  always @(negedge clk) begin
    logic          e_valid;
    logic          e_last;
    logic [DW-1:0] e_data;
    logic [2:0]    e_ready;
    int  need [3];
    bit  el [3];
    int  dh [3];
    int  dd [3];
    int  got;
    int  nst;
    int  t;
    if (!rst_n) begin
      mst = 0; mg = 0; mptr = 0; merr = 1'b0;
      for (int c = 0; c < 3; c++) begin
        mh[c] = 0; md[c] = 0; ih[c] = 1'b0; idf[c] = 1'b0;
      end
    end
    e_valid = 1'b0; e_last = 1'b0; e_data = '0; e_ready = '0;
    if (mst == 2) begin
      e_valid = src_valid[mg];
      e_data = src_data[mg*DW +: DW];
      e_last = src_last[mg];
      e_ready[mg] = tx_ready;
    end
    chk("tx_valid", DW'(tx_valid), DW'(e_valid));
    chk("tx_last", DW'(tx_last), DW'(e_last));
    chk("tx_data", tx_data, e_data);
    chk("src_ready", DW'(src_ready), DW'(e_ready));
    chk("tx_class", DW'(tx_class), DW'(mg));
    chk("fc_err", DW'(fc_err), DW'(merr));
    if (rst_n) begin
      got = -1;
      nst = mst;
      for (int c = 0; c < 3; c++) begin
        dh[c] = 0; dd[c] = 0;
        need[c] = (int'(src_len_dw[c*LW +: LW]) + 3) / 4;
        el[c] = src_valid[c] && (ih[c] || mh[c] >= 1)
                && (idf[c] || md[c] >= need[c]);
      end
      if (mst == 0 && fc_init_valid) nst = 1;
      if (mst == 1) begin
`ifdef PCIE_TX_ARB_CPL_PRIO_EN
        if (el[2]) got = 2;
        else
          for (int k = 0; k < 2; k++)
            if (got < 0 && el[(mptr + k) % 2]) got = (mptr + k) % 2;
        if (got == 0 || got == 1) mptr = (got + 1) % 2;
`else
        for (int k = 0; k < 3; k++)
          if (got < 0 && el[(mptr + k) % 3]) got = (mptr + k) % 3;
        if (got >= 0) mptr = (got + 1) % 3;
`endif
        if (got >= 0) begin
          mg = got;
          nst = 2;
          dh[got] = 1;
          dd[got] = need[got];
        end
      end
      if (mst == 2 && e_valid && tx_ready && e_last) nst = 1;
      for (int c = 0; c < 3; c++) begin
        if (fc_init_valid) begin
          mh[c] = int'(fc_init_hdr[c*HW +: HW]);
          md[c] = int'(fc_init_data[c*CW +: CW]);
          ih[c] = (mh[c] == 0);
          idf[c] = (md[c] == 0);
        end else begin
          if (!ih[c]) begin
            t = mh[c] - dh[c];
            if (fc_upd_valid && fc_upd_class == 2'(c)) t += int'(fc_upd_hdr);
            if (t > 255) begin t = 255; merr = 1'b1; end
            mh[c] = t;
          end
          if (!idf[c]) begin
            t = md[c] - dd[c];
            if (fc_upd_valid && fc_upd_class == 2'(c)) t += int'(fc_upd_data);
            if (t > 4095) begin t = 4095; merr = 1'b1; end
            md[c] = t;
          end
        end
      end
      mst = nst;
    end
  end

  task automatic push(int c, int len, int nb, int id);
    tlp_t t;
    t.len = len; t.beats = nb; t.id = id;
    srcq[c].push_back(t);
  endtask

  task automatic do_init(int h0, int h1, int h2, int d0, int d1, int d2);
    @(posedge clk); #2;
    fc_init_hdr = {HW'(h2), HW'(h1), HW'(h0)};
    fc_init_data = {CW'(d2), CW'(d1), CW'(d0)};
    fc_init_valid = 1'b1;
    @(posedge clk); #2;
    fc_init_valid = 1'b0;
  endtask

  task automatic do_upd(int c, int h, int d);
    @(posedge clk); #2;
    fc_upd_class = 2'(c); fc_upd_hdr = HW'(h); fc_upd_data = CW'(d);
    fc_upd_valid = 1'b1;
    @(posedge clk); #2;
    fc_upd_valid = 1'b0;
  endtask

  task automatic wait_log(int n, int budget);
    int k = 0;
    while (glog.size() < n && k < budget) begin
      @(posedge clk); #2;
      k++;
    end
    chk("wait_tlp", DW'(glog.size() >= n), DW'(1));
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      srcq[c].delete();
      bidx[c] = 0;
    end
    tx_ready = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b1;
    glog.delete();
    gcyc.delete();
  endtask

  initial begin
    int n;
    int b0;
    int k;
    int ord [6];
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tx_valid", DW'(tx_valid), DW'(0));
    chk("rst_src_ready", DW'(src_ready), DW'(0));
    chk("rst_fc_err", DW'(fc_err), DW'(0));
    rst_n = 1'b1;

    // 32DW P TLP in 4 beats consumes all 8 P data credits
    do_init(4, 4, 4, 8, 0, 8);
    push(0, 32, 4, 1);
    wait_log(1, 50);
    chk("t1_p_beats", DW'(beats[0]), DW'(4));
    chk("t1_class", DW'(glog[0]), DW'(0));

    // starved P does not block NP; one returned credit releases P
    push(0, 4, 1, 2);
    push(1, 0, 1, 3);
    wait_log(2, 50);
    chk("t2_np_first", DW'(glog[1]), DW'(1));
    repeat (8) @(posedge clk);
    #2;
    chk("t2_p_blocked", DW'(glog.size()), DW'(2));
    do_upd(0, 0, 1);
    wait_log(3, 50);
    chk("t2_p_after_upd", DW'(glog[2]), DW'(0));

    // all three contending with infinite credits
    do_reset();
    do_init(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      push(c, 8, 1, 10 + c);
      push(c, 8, 1, 20 + c);
    end
    wait_log(6, 80);
`ifdef PCIE_TX_ARB_CPL_PRIO_EN
    ord = '{2, 2, 0, 1, 0, 1};
`else
    ord = '{0, 1, 2, 0, 1, 2};
`endif
    for (int i = 0; i < 6; i++) chk("t3_order", DW'(glog[i]), DW'(ord[i]));
    for (int i = 1; i < 6; i++)
      chk("t3_spacing", DW'(gcyc[i] - gcyc[i-1]), DW'(2));

    // same-cycle return and deduction: 5 + 1 - 2 = 4
    do_init(4, 4, 4, 5, 0, 0);
    n = glog.size();
    push(0, 8, 1, 30);
    @(posedge clk); #2;
    fc_upd_class = 2'd0; fc_upd_hdr = '0; fc_upd_data = CW'(1);
    fc_upd_valid = 1'b1;
    @(posedge clk); #2;
    fc_upd_valid = 1'b0;
    wait_log(n + 1, 30);
    push(0, 16, 1, 31);
    wait_log(n + 2, 30);
    push(0, 4, 1, 32);
    repeat (10) @(posedge clk);
    #2;
    chk("t5_p_exhausted", DW'(glog.size()), DW'(n + 2));
    do_upd(1, 0, 4095);
    do_upd(1, 0, 4095);
    chk("t5_inf_ignored", DW'(fc_err), DW'(0));
    do_upd(0, 0, 4095);
    wait_log(n + 3, 30);
    do_upd(0, 0, 1);
    chk("t5_at_max", DW'(fc_err), DW'(0));
    do_upd(0, 0, 1);
    chk("t5_saturate", DW'(fc_err), DW'(1));

    // stall mid-TLP, then async reset
    do_reset();
    do_init(0, 0, 0, 0, 0, 0);
    b0 = beats[0];
    push(0, 32, 4, 40);
    k = 0;
    while (beats[0] == b0 && k < 30) begin
      @(posedge clk); #2;
      k++;
    end
    chk("t6_first_beat", DW'(beats[0] - b0), DW'(1));
    tx_ready = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      chk("t6_stall_valid", DW'(tx_valid), DW'(1));
      chk("t6_stall_data", tx_data, beat_data(0, 40, 1));
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", DW'(tx_valid), DW'(0));
    chk("t6_rst_data", tx_data, DW'(0));
    chk("t6_rst_class", DW'(tx_class), DW'(0));
    for (int c = 0; c < 3; c++) begin
      srcq[c].delete();
      bidx[c] = 0;
    end
    tx_ready = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b1;
    n = glog.size();
    push(0, 4, 1, 41);
    repeat (10) @(posedge clk);
    #2;
    chk("t6_idle_no_grant", DW'(glog.size()), DW'(n));
    do_init(4, 4, 4, 4, 4, 4);
    wait_log(n + 1, 30);
    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
